sdram_write_arbiter: RTL and testbench
======================================

SDRAM_WRITE_ARBITER -- requirements
Module: sdram_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive requester-0 grants after which a pending requester 1 is forced in (guard build only).
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 m0_address, m0_write, m0_writedata  in  32/1/16  requester 0: video stream DMA pixel write.
REQ-005 m0_waitrequest  out  1  stall to requester 0.
REQ-006 m1_address, m1_write, m1_writedata  in  32/1/16  requester 1: overlay/box-draw pixel write.
REQ-007 m1_waitrequest  out  1  stall to requester 1.
REQ-008 master_address, master_write, master_writedata  out  32/1/16  shared SDRAM write port.
REQ-009 master_waitrequest  in  1  stall from SDRAM port.
REQ-010 grant  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-011 FSM states IDLE, GRANT0, GRANT1; state and grant registered.
REQ-012 IDLE: master_write=0; m0_waitrequest=m1_waitrequest=1.
REQ-013 IDLE -> GRANT0 if m0_write; else -> GRANT1 if m1_write; else stay (fixed priority, requester 0 highest).
REQ-014 Latency: master_write asserts the cycle after the grant decision; no combinational path from mN_write to master_write.
REQ-015 GRANTn: master_address/write/writedata = mN signals; mN_waitrequest = master_waitrequest; other requester waitrequest=1.
REQ-016 Transfer completes on the cycle with master_write=1 and master_waitrequest=0.
REQ-017 On completion, re-arbitrate per REQ-013 using the same cycle's request inputs (back-to-back, no idle bubble); no requests -> IDLE.
REQ-018 Owner never changes while master_waitrequest=1.
REQ-019 Owner drops mN_write before completion (protocol violation): -> IDLE next cycle, no write issued.
REQ-020 Simultaneous m0_write and m1_write at a decision point -> requester 0 wins (unless REQ-027 applies).
REQ-021 Non-owner request inputs ignored; address/data never mixed between requesters.

Reset
REQ-022 reset forces state IDLE, grant=2'b00, master_write=0, master_address=0, master_writedata=0, m0_waitrequest=m1_waitrequest=1, starvation counter=0.
REQ-023 reset mid-transfer aborts immediately; the pending write is not issued; requesters re-request after reset.
REQ-024 First grant possible on the first cycle after reset deasserts.

Configuration
REQ-025 Macro ARB_STARVE_GUARD_EN compiles in the starvation guard.
REQ-026 With macro: counter (width clog2(STARVE_LIMIT+1)) increments on each requester-0 completion while m1_write=1; clears on any requester-1 completion or when m1_write=0.
REQ-027 With macro: counter==STARVE_LIMIT at a decision point with m1_write=1 -> GRANT1 regardless of m0_write.
REQ-028 Without macro: pure fixed priority, no counter present; requester 1 can starve indefinitely.

Verification
REQ-029 Only m1_write=1, addr 0x100, data 0xABCD, waitrequest=0 -> grant=2'b10 next cycle, one master write 0x100/0xABCD, then IDLE.
REQ-030 m0 and m1 request together, waitrequest=0 -> m0 write first, m1 write on the immediately following cycle, m1_waitrequest=1 throughout the m0 beat.
REQ-031 m0 granted, master_waitrequest held high 5 cycles with m1 requesting -> m0 address/data stable on master for 6 cycles, grant stays 2'b01, m1 stalled.
REQ-032 reset pulsed during GRANT0 with waitrequest=1 -> next cycle master_write=0, grant=2'b00, both waitrequests=1.
REQ-033 Guard build, STARVE_LIMIT=8, m0 and m1 continuously requesting -> exactly 8 m0 writes then one m1 write, repeating; non-guard build -> zero m1 writes over 100 cycles.

Source files
------------

// File: rtl/sdram_write_arbiter.sv
// sdram_write_arbiter
// Two-requester arbiter for the shared SDRAM write port. Requester 0 (video
// stream DMA) has fixed priority over requester 1 (overlay/box draw).
// The owning requester's beat is captured into the master-side registers at the
// clock edge that grants it. That requester then presents its next beat, or
// drops its write, from the following cycle. A captured beat is held on the
// master port until master_waitrequest is low.
// Optional feature: define ARB_STARVE_GUARD_EN to compile in a starvation guard.
// With the guard, requester 1 is forced in after STARVE_LIMIT consecutive
// requester-0 writes.
module sdram_write_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_write,
    input  logic [15:0] m0_writedata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic        m1_write,
    input  logic [15:0] m1_writedata,
    output logic        m1_waitrequest,

    output logic [31:0] master_address,
    output logic        master_write,
    output logic [15:0] master_writedata,
    input  logic        master_waitrequest,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;

    logic complete;      // master accepts the beat this cycle
    logic owner_drop;    // owner withdrew while its beat was still stalled
    logic decide;        // arbitration point: idle or a beat just completed
    logic starve_force;  // requester 1 must win this decision
    logic pick0;
    logic pick1;

    assign complete   = master_write & ~master_waitrequest;
    assign owner_drop = ((state == GRANT0) & ~m0_write) |
                        ((state == GRANT1) & ~m1_write);
    assign decide     = (state == IDLE) | complete;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W:0]   starve_eff;

    // Count for this decision: includes an m0 beat completing now, and is zero
    // once m1 has just been served.
    always_comb begin
        starve_eff = {1'b0, starve_cnt};
        if (complete && (state == GRANT1)) begin
            starve_eff = '0;
        end else if (complete && (state == GRANT0)) begin
            starve_eff = {1'b0, starve_cnt} + (CNT_W + 1)'(1);
        end
    end

    assign starve_force = m1_write && (starve_eff >= (CNT_W + 1)'(STARVE_LIMIT));

    // Consecutive m0 completions while m1 waits; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset || !m1_write) begin
            starve_cnt <= '0;
        end else if (complete && (state == GRANT1)) begin
            starve_cnt <= '0;
        end else if (complete && (state == GRANT0) &&
                     (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Fixed priority: m0 wins unless it is idle or the starvation guard fires.
    assign pick1 = m1_write & (~m0_write | starve_force);
    assign pick0 = m0_write & ~pick1;

    // Arbitration FSM; captures the winner's beat into the master port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            grant            <= 2'b00;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else if (decide) begin
            if (pick0) begin
                state            <= GRANT0;
                grant            <= 2'b01;
                master_write     <= 1'b1;
                master_address   <= m0_address;
                master_writedata <= m0_writedata;
            end else if (pick1) begin
                state            <= GRANT1;
                grant            <= 2'b10;
                master_write     <= 1'b1;
                master_address   <= m1_address;
                master_writedata <= m1_writedata;
            end else begin
                state        <= IDLE;
                grant        <= 2'b00;
                master_write <= 1'b0;
            end
        end else if (owner_drop) begin
            // Abandon the stalled beat; it never completes on the master.
            state        <= IDLE;
            grant        <= 2'b00;
            master_write <= 1'b0;
        end
    end

    // Only the owner sees the master stall; everyone else is held off.
    always_comb begin
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state == GRANT0) begin
            m0_waitrequest = master_waitrequest;
        end else if (state == GRANT1) begin
            m1_waitrequest = master_waitrequest;
        end
    end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Directed testbench for sdram_write_arbiter. Inputs are driven 1 ns after
// each rising edge, and outputs are sampled 1 ns after that. A requester treats
// its beat as taken at the edge that grants it.
// Expectations follow ARB_STARVE_GUARD_EN when the macro is defined.
`timescale 1ns/1ps
module tb_sdram_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, master_address;
    logic        m0_write, m1_write, master_write;
    logic [15:0] m0_writedata, m1_writedata, master_writedata;
    logic        m0_waitrequest, m1_waitrequest, master_waitrequest;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    sdram_write_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .m0_address         (m0_address),
        .m0_write           (m0_write),
        .m0_writedata       (m0_writedata),
        .m0_waitrequest     (m0_waitrequest),
        .m1_address         (m1_address),
        .m1_write           (m1_write),
        .m1_writedata       (m1_writedata),
        .m1_waitrequest     (m1_waitrequest),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .grant              (grant)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_write = 1'b0; m1_write = 1'b0; master_waitrequest = 1'b0;
        m0_address = 32'h0; m1_address = 32'h0;
        m0_writedata = 16'h0; m1_writedata = 16'h0;
        tick(); tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL reset_mwrite got %b want 0", master_write); end
        checks++; if (master_address !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h want 0", master_address); end
        checks++; if (master_writedata !== 16'h0) begin errors++; $display("FAIL reset_mdata got %h want 0", master_writedata); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m0wait got %b want 1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m1wait got %b want 1", m1_waitrequest); end
    endtask

    // m1 alone, issued in the very first cycle after reset is released.
    task automatic test_m1_only();
        reset = 1'b0;
        m1_write = 1'b1; m1_address = 32'h100; m1_writedata = 16'hABCD;
        master_waitrequest = 1'b0;
        settle();
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL m1only_idle_mwrite got %b want 0", master_write); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL m1only_idle_m1wait got %b want 1", m1_waitrequest); end
        tick();
        m1_write = 1'b0;
        settle();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL m1only_grant got %b want 10", grant); end
        checks++; if (master_write !== 1'b1) begin errors++; $display("FAIL m1only_mwrite got %b want 1", master_write); end
        checks++; if (master_address !== 32'h100) begin errors++; $display("FAIL m1only_maddr got %h want 100", master_address); end
        checks++; if (master_writedata !== 16'hABCD) begin errors++; $display("FAIL m1only_mdata got %h want abcd", master_writedata); end
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL m1only_m1wait got %b want 0", m1_waitrequest); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL m1only_m0wait got %b want 1", m0_waitrequest); end
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL m1only_end_grant got %b want 00", grant); end
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL m1only_end_mwrite got %b want 0", master_write); end
    endtask

    task automatic test_simultaneous();
        m0_write = 1'b1; m0_address = 32'h200; m0_writedata = 16'h1111;
        m1_write = 1'b1; m1_address = 32'h300; m1_writedata = 16'h2222;
        master_waitrequest = 1'b0;
        tick();
        m0_write = 1'b0;
        settle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL simul_first_grant got %b want 01", grant); end
        checks++; if (master_write !== 1'b1) begin errors++; $display("FAIL simul_first_mwrite got %b want 1", master_write); end
        checks++; if (master_address !== 32'h200) begin errors++; $display("FAIL simul_first_maddr got %h want 200", master_address); end
        checks++; if (master_writedata !== 16'h1111) begin errors++; $display("FAIL simul_first_mdata got %h want 1111", master_writedata); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL simul_m1wait got %b want 1", m1_waitrequest); end
        tick();
        m1_write = 1'b0;
        settle();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL simul_second_grant got %b want 10", grant); end
        checks++; if (master_write !== 1'b1) begin errors++; $display("FAIL simul_second_mwrite got %b want 1", master_write); end
        checks++; if (master_address !== 32'h300) begin errors++; $display("FAIL simul_second_maddr got %h want 300", master_address); end
        checks++; if (master_writedata !== 16'h2222) begin errors++; $display("FAIL simul_second_mdata got %h want 2222", master_writedata); end
        tick();
        settle();
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL simul_end_mwrite got %b want 0", master_write); end
    endtask

    // master stalls m0 for 5 cycles while m1 keeps requesting.
    task automatic test_stall();
        m0_write = 1'b1; m0_address = 32'h400; m0_writedata = 16'h3333;
        m1_write = 1'b1; m1_address = 32'h500; m1_writedata = 16'h4444;
        master_waitrequest = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 5) begin
                master_waitrequest = 1'b0;
                m0_write = 1'b0;
            end
            settle();
            checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stall_grant c%0d got %b want 01", c, grant); end
            checks++; if (master_write !== 1'b1 || master_address !== 32'h400 || master_writedata !== 16'h3333) begin
                errors++; $display("FAIL stall_beat c%0d got %b %h %h want 1 400 3333", c, master_write, master_address, master_writedata);
            end
            checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_m1wait c%0d got %b want 1", c, m1_waitrequest); end
            checks++; if (m0_waitrequest !== master_waitrequest) begin errors++; $display("FAIL stall_m0wait c%0d got %b want %b", c, m0_waitrequest, master_waitrequest); end
        end
        tick();
        m1_write = 1'b0;
        settle();
        checks++; if (grant !== 2'b10 || master_address !== 32'h500) begin
            errors++; $display("FAIL stall_then_m1 got %b %h want 10 500", grant, master_address);
        end
        tick();
    endtask

    task automatic test_abort();
        m0_write = 1'b1; m0_address = 32'h600; m0_writedata = 16'h5555;
        master_waitrequest = 1'b1;
        tick();
        m0_write = 1'b0;
        settle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abort_grant got %b want 01", grant); end
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_idle_grant got %b want 00", grant); end
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL abort_mwrite got %b want 0", master_write); end
    endtask

    task automatic test_reset_mid();
        m0_write = 1'b1; m0_address = 32'h700; m0_writedata = 16'h6666;
        master_waitrequest = 1'b1;
        tick();
        reset = 1'b1;
        settle();
        checks++; if (grant !== 2'b01 || master_write !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got %b %b want 01 1", grant, master_write);
        end
        tick();
        reset = 1'b0; m0_write = 1'b0; master_waitrequest = 1'b0;
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant got %b want 00", grant); end
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL rstmid_mwrite got %b want 0", master_write); end
        checks++; if (master_address !== 32'h0) begin errors++; $display("FAIL rstmid_maddr got %h want 0", master_address); end
        checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rstmid_waits got %b %b want 1 1", m0_waitrequest, m1_waitrequest);
        end
        tick();
    endtask

    // Both requesters continuously present beats; write k lands in cycle k.
    task automatic test_starvation();
        int n0 = 0;
        int n1 = 0;
        int order_bad = 0;
        int exp0;
        int exp1;
        m0_write = 1'b1; m0_address = 32'h800; m0_writedata = 16'h0800;
        m1_write = 1'b1; m1_address = 32'h900; m1_writedata = 16'h0900;
        master_waitrequest = 1'b0;
        for (int k = 1; k <= 99; k++) begin
            tick();
            settle();
            if (master_write === 1'b1 && master_address === 32'h800) n0++;
            else if (master_write === 1'b1 && master_address === 32'h900) n1++;
`ifdef ARB_STARVE_GUARD_EN
            if (master_address !== ((k % 9 == 0) ? 32'h900 : 32'h800)) order_bad++;
`else
            if (master_address !== 32'h800) order_bad++;
`endif
        end
`ifdef ARB_STARVE_GUARD_EN
        exp0 = 88; exp1 = 11;
`else
        exp0 = 99; exp1 = 0;
`endif
        checks++; if (n0 !== exp0) begin errors++; $display("FAIL starve_m0_writes got %0d want %0d", n0, exp0); end
        checks++; if (n1 !== exp1) begin errors++; $display("FAIL starve_m1_writes got %0d want %0d", n1, exp1); end
        checks++; if (order_bad !== 0) begin errors++; $display("FAIL starve_order bad_cycles %0d want 0", order_bad); end
        m0_write = 1'b0; m1_write = 1'b0;
        tick(); tick();
        settle();
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL starve_end_mwrite got %b want 0", master_write); end
    endtask

    initial begin
        test_reset();
        test_m1_only();
        test_simultaneous();
        test_stall();
        test_abort();
        test_reset_mid();
        test_starvation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
